// File: rtl/inst_fifo_pkg.sv
// Shared CPU package.
// Holds the instruction-queue entry layout and the default queue depth used
// wherever the fetch and decode stages meet.
package inst_fifo_pkg;

    localparam int INST_FIFO_DEPTH = 16;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] inst;
    } inst_entry_t;

endpackage

// File: rtl/inst_fifo.sv
// inst_fifo
// Dual-push / dual-pop instruction queue between the fetch splitter and the
// dual-issue decoder. Reads are first-word-fall-through: the head and head+1
// entries are presented combinationally and are zeroed when not valid.
//
// Ports
//   clk                       single clock, rising edge
//   rst                       asynchronous active-high reset, drops all entries
//   flush                     drop all entries at the next edge (highest priority)
//   write_en1 / write_en2     push slot 1 / slot 2 (slot 2 needs slot 1)
//   write_inst1/2, write_addr1/2   instruction words and their PCs
//   read_en1 / read_en2       pop head / head+1 (head+1 needs head)
//   read_inst1/2, read_addr1/2     head and head+1 contents (0 when invalid)
//   read_valid1 / read_valid2 at least 1 / at least 2 entries present
//   full                      fewer than 2 free entries
//   empty                     no entries
module inst_fifo
    import inst_fifo_pkg::*;
#(
    parameter int DEPTH = INST_FIFO_DEPTH
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        write_en1,
    input  logic        write_en2,
    input  logic [31:0] write_inst1,
    input  logic [31:0] write_inst2,
    input  logic [31:0] write_addr1,
    input  logic [31:0] write_addr2,
    input  logic        read_en1,
    input  logic        read_en2,
    output logic [31:0] read_inst1,
    output logic [31:0] read_inst2,
    output logic [31:0] read_addr1,
    output logic [31:0] read_addr2,
    output logic        read_valid1,
    output logic        read_valid2,
    output logic        full,
    output logic        empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("inst_fifo: DEPTH must be a power of two and at least 4");
    end

    inst_entry_t     mem [DEPTH];
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [CW-1:0]   count;
    logic [PW-1:0]   head_p1;
    logic [PW-1:0]   tail_p1;
    logic [1:0]      wcnt;
    logic [1:0]      rcnt;

    assign head_p1 = head + PW'(1);
    assign tail_p1 = tail + PW'(1);

    // Full leaves room for one more pair, so a push accepted while full is
    // low can never overflow.
    assign full  = (count >= CW'(DEPTH - 1));
    assign empty = (count == '0);

    always_comb begin
        wcnt = 2'd0;
        if (write_en1) begin
            wcnt = write_en2 ? 2'd2 : 2'd1;
        end
        if (full) begin
            wcnt = 2'd0;
        end
    end

    // Pops are clipped to what is present, so count never wraps below zero.
    always_comb begin
        rcnt = 2'd0;
        if (read_en1 && read_en2 && count >= CW'(2)) begin
            rcnt = 2'd2;
        end else if (read_en1 && count >= CW'(1)) begin
            rcnt = 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PW'(rcnt);
            tail  <= tail + PW'(wcnt);
            count <= count + CW'(wcnt) - CW'(rcnt);
        end
    end

    // Storage is not reset; validity is tracked entirely by count.
    always_ff @(posedge clk) begin
        if (!flush && wcnt != 2'd0) begin
            mem[tail] <= '{addr: write_addr1, inst: write_inst1};
        end
        if (!flush && wcnt == 2'd2) begin
            mem[tail_p1] <= '{addr: write_addr2, inst: write_inst2};
        end
    end

    always_comb begin
        read_valid1 = (count >= CW'(1));
        read_valid2 = (count >= CW'(2));
        read_inst1  = 32'h0;
        read_addr1  = 32'h0;
        read_inst2  = 32'h0;
        read_addr2  = 32'h0;
        if (read_valid1) begin
            read_inst1 = mem[head].inst;
            read_addr1 = mem[head].addr;
        end
        if (read_valid2) begin
            read_inst2 = mem[head_p1].inst;
            read_addr2 = mem[head_p1].addr;
        end
    end

endmodule

// File: tb/tb_inst_fifo.sv
// tb_inst_fifo
// Directed bench for inst_fifo (DEPTH=16). Expected values are hand-derived
// from the PCs pushed; instruction words are {8'h24, addr[23:0]} except in
// the opening pair, which uses the literal words from the reference sequence.
module tb_inst_fifo;
    import inst_fifo_pkg::*;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        write_en1, write_en2;
    logic [31:0] write_inst1, write_inst2, write_addr1, write_addr2;
    logic        read_en1, read_en2;
    logic [31:0] read_inst1, read_inst2, read_addr1, read_addr2;
    logic        read_valid1, read_valid2, full, empty;

    int n_assert = 0;
    int n_fail   = 0;

    inst_fifo #(.DEPTH(16)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .write_en1(write_en1), .write_en2(write_en2),
        .write_inst1(write_inst1), .write_inst2(write_inst2),
        .write_addr1(write_addr1), .write_addr2(write_addr2),
        .read_en1(read_en1), .read_en2(read_en2),
        .read_inst1(read_inst1), .read_inst2(read_inst2),
        .read_addr1(read_addr1), .read_addr2(read_addr2),
        .read_valid1(read_valid1), .read_valid2(read_valid2),
        .full(full), .empty(empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] iw(input logic [31:0] a);
        return {8'h24, a[23:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        write_en1 = 0; write_en2 = 0; read_en1 = 0; read_en2 = 0; flush = 0;
    endtask

    // Drive a push (n = 0, 1 or 2 entries starting at PC a) and a pop request.
    task automatic drive(input int n, input logic [31:0] a, input logic r1, input logic r2);
        write_en1   = (n >= 1);
        write_en2   = (n == 2);
        write_addr1 = a;
        write_addr2 = a + 32'd4;
        write_inst1 = iw(a);
        write_inst2 = iw(a + 32'd4);
        read_en1    = r1;
        read_en2    = r2;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        write_inst1 = '0; write_inst2 = '0; write_addr1 = '0; write_addr2 = '0;
        #12;
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_rv1", 32'(read_valid1), 32'd0);
        chk("rst_rv2", 32'(read_valid2), 32'd0);
        chk("rst_addr1", read_addr1, 32'h0);
        chk("rst_inst1", read_inst1, 32'h0);

        // First write after reset is taken on the very next edge.
        @(negedge clk);
        rst = 1'b0;
        write_en1 = 1; write_en2 = 1;
        write_addr1 = 32'h1000; write_inst1 = 32'h24010001;
        write_addr2 = 32'h1004; write_inst2 = 32'h24020002;
        tick();
        idle();
        chk("pair_rv1", 32'(read_valid1), 32'd1);
        chk("pair_rv2", 32'(read_valid2), 32'd1);
        chk("pair_addr1", read_addr1, 32'h1000);
        chk("pair_addr2", read_addr2, 32'h1004);
        chk("pair_inst1", read_inst1, 32'h24010001);
        chk("pair_inst2", read_inst2, 32'h24020002);
        chk("pair_empty", 32'(empty), 32'd0);

        drive(0, 0, 1, 1); tick(); idle();
        chk("pop2_empty", 32'(empty), 32'd1);
        chk("pop2_rv1", 32'(read_valid1), 32'd0);
        chk("pop2_addr1", read_addr1, 32'h0);

        // Fill to 14 then 16 entries.
        for (int k = 0; k < 7; k++) begin
            drive(2, 32'h2000 + 32'(8 * k), 0, 0); tick();
        end
        idle();
        chk("fill14_full", 32'(full), 32'd0);
        chk("fill14_addr1", read_addr1, 32'h2000);
        chk("fill14_addr2", read_addr2, 32'h2004);
        drive(2, 32'h2038, 0, 0); tick(); idle();
        chk("fill16_full", 32'(full), 32'd1);
        drive(2, 32'h3000, 0, 0); tick(); idle();
        chk("rej_full", 32'(full), 32'd1);
        chk("rej_head", read_addr1, 32'h2000);
        drive(0, 0, 1, 0); tick(); idle();
        chk("c15_full", 32'(full), 32'd1);
        chk("c15_addr1", read_addr1, 32'h2004);
        chk("c15_addr2", read_addr2, 32'h2008);
        drive(0, 0, 1, 0); tick(); idle();
        chk("c14_full", 32'(full), 32'd0);
        for (int k = 0; k < 7; k++) begin
            chk("drain_addr1", read_addr1, 32'h2008 + 32'(8 * k));
            chk("drain_addr2", read_addr2, 32'h200C + 32'(8 * k));
            drive(0, 0, 1, 1); tick();
        end
        idle();
        chk("drain_empty", 32'(empty), 32'd1);

        // write_en2 alone is ignored.
        write_en2 = 1; tick(); idle();
        chk("we2_only_empty", 32'(empty), 32'd1);

        // Single entry, dual read: only one pops.
        drive(1, 32'h4000, 0, 0); tick(); idle();
        chk("one_rv1", 32'(read_valid1), 32'd1);
        chk("one_rv2", 32'(read_valid2), 32'd0);
        chk("one_addr2", read_addr2, 32'h0);
        chk("one_inst2", read_inst2, 32'h0);
        chk("one_inst1", read_inst1, iw(32'h4000));
        drive(0, 0, 1, 1); #1;
        chk("one_rd_rv2", 32'(read_valid2), 32'd0);
        tick(); idle();
        chk("one_rd_empty", 32'(empty), 32'd1);
        chk("one_rd_rv1", 32'(read_valid1), 32'd0);

        // count=3, push pair while popping pair.
        drive(2, 32'h6000, 0, 0); tick();
        drive(1, 32'h6008, 0, 0); tick();
        drive(2, 32'h7000, 1, 1); tick(); idle();
        chk("mix_addr1", read_addr1, 32'h6008);
        chk("mix_addr2", read_addr2, 32'h7000);
        drive(0, 0, 1, 1); tick(); idle();
        chk("mix_last_addr1", read_addr1, 32'h7004);
        chk("mix_last_rv2", 32'(read_valid2), 32'd0);
        drive(0, 0, 1, 0); tick(); idle();
        chk("mix_empty", 32'(empty), 32'd1);

        // Sustained streaming across the index wrap.
        drive(2, 32'h8000, 0, 0); tick();
        for (int i = 0; i < 20; i++) begin
            chk("wrap_addr1", read_addr1, 32'h8000 + 32'(8 * i));
            chk("wrap_addr2", read_addr2, 32'h8004 + 32'(8 * i));
            drive(2, 32'h8000 + 32'(8 * (i + 1)), 1, 1); tick();
        end
        idle();
        chk("wrap_tail_inst1", read_inst1, iw(32'h80A0));
        drive(0, 0, 1, 1); tick(); idle();
        chk("wrap_empty", 32'(empty), 32'd1);

        // Flush at count=9 with a simultaneous write.
        for (int k = 0; k < 4; k++) begin
            drive(2, 32'h9000 + 32'(8 * k), 0, 0); tick();
        end
        drive(1, 32'h9020, 0, 0); tick();
        drive(2, 32'h9800, 1, 1); flush = 1; #1;
        chk("flush_pre_rv1", 32'(read_valid1), 32'd1);
        chk("flush_pre_addr1", read_addr1, 32'h9000);
        tick(); idle();
        chk("flush_empty", 32'(empty), 32'd1);
        chk("flush_rv1", 32'(read_valid1), 32'd0);
        chk("flush_full", 32'(full), 32'd0);
        drive(2, 32'h9100, 0, 0); tick(); idle();
        chk("post_flush_addr1", read_addr1, 32'h9100);
        chk("post_flush_addr2", read_addr2, 32'h9104);

        // Reset pulse mid-stream takes effect before any clock edge.
        rst = 1; #1;
        chk("rst_mid_empty", 32'(empty), 32'd1);
        chk("rst_mid_rv1", 32'(read_valid1), 32'd0);
        chk("rst_mid_addr1", read_addr1, 32'h0);
        #1; rst = 0;
        drive(2, 32'hA000, 0, 0); tick(); idle();
        chk("post_rst_addr1", read_addr1, 32'hA000);
        chk("post_rst_rv2", 32'(read_valid2), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
